// File: rtl/ex_pkg.sv
// Shared opcode/class encodings and divider state type for the execute stage.
package ex_pkg;
    localparam int REG_W = 32;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [REG_W-1:0] neg32(input logic [REG_W-1:0] v);
        return ~v + 32'd1;
    endfunction
endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider: one quotient bit per BUSY cycle, signs
// applied on the last iteration so DONE presents final HI/LO values.
module ex_div
    import ex_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    input  logic        hold_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    div_state_e       state_q;
    logic [63:0]      dq_q;      // {partial remainder, quotient}
    logic [31:0]      dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             negq_q, negr_q;

    logic [31:0] mag1, mag2, q_fix, r_fix;
    logic [32:0] trial;
    logic [63:0] step_d;

    always_comb begin
        mag1   = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
        mag2   = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
        trial  = dq_q[63:31] - {1'b0, dvs_q};
        step_d = trial[32] ? {dq_q[62:0], 1'b0} : {trial[31:0], dq_q[30:0], 1'b1};
        q_fix  = negq_q ? neg32(step_d[31:0])  : step_d[31:0];
        r_fix  = negr_q ? neg32(step_d[63:32]) : step_d[63:32];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            dq_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else if (annul_i) begin
            state_q <= DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (start_i) begin
                    if (opdata2_i == '0) begin
                        dq_q    <= {opdata1_i, 32'hFFFF_FFFF};
                        state_q <= DIV_DONE;
                    end else begin
                        dq_q    <= {32'd0, mag1};
                        dvs_q   <= mag2;
                        cnt_q   <= '0;
                        negq_q  <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        negr_q  <= signed_div_i && opdata1_i[31];
                        state_q <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                        dq_q    <= {r_fix, q_fix};
                        state_q <= DIV_DONE;
                    end else begin
                        dq_q  <= step_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DIV_DONE: if (!hold_i) state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

    assign result_o = dq_q;
    assign ready_o  = (state_q == DIV_DONE);
    assign busy_o   = (state_q == DIV_BUSY);
endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle ALU with overflow-suppressed writes, plus the
// HI/LO divide path and the pipeline stall request it needs.
module ex
    import ex_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);
    logic [31:0] logic_res, shift_res, arith_res, res, sum, diff;
    logic        ovf, is_div, div_ready, div_busy;
    logic [63:0] div_res;

    always_comb begin
        sum  = reg1_i + reg2_i;
        diff = reg1_i - reg2_i;

        logic_res = '0;
        case (aluop_i)
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase

        shift_res = '0;
        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            default: shift_res = '0;
        endcase

        arith_res = '0;
        case (aluop_i)
            OP_ADD, OP_ADDU: arith_res = sum;
            OP_SUB, OP_SUBU: arith_res = diff;
            OP_SLT:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            OP_SLTU: arith_res = {31'd0, reg1_i < reg2_i};
            default: arith_res = '0;
        endcase

        res = '0;
        case (alusel_i)
            SEL_LOGIC: res = logic_res;
            SEL_SHIFT: res = shift_res;
            SEL_ARITH: res = arith_res;
            default:   res = '0;
        endcase

        // Signed overflow: result sign disagrees with the operand sign(s) it should follow.
        ovf = ((aluop_i == OP_ADD) && (reg1_i[31] == reg2_i[31]) && (sum[31]  != reg1_i[31])) ||
              ((aluop_i == OP_SUB) && (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]));
        is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    end

    ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk          (clk),
        .rst          (rst),
        .start_i      (is_div),
        .signed_div_i (aluop_i == OP_DIV),
        .opdata1_i    (reg1_i),
        .opdata2_i    (reg2_i),
        .annul_i      (flush_i),
        .hold_i       (stall_i),
        .result_o     (div_res),
        .ready_o      (div_ready),
        .busy_o       (div_busy)
    );

    // Outputs are forced low while reset is held, combinational paths included.
    assign wd_o       = rst ? wd_i : '0;
    assign wreg_o     = rst & wreg_i & ~ovf & ~is_div;
    assign wdata_o    = rst ? res : '0;
    assign whilo_o    = rst & div_ready & ~flush_i;
    assign hi_o       = (rst && div_ready) ? div_res[63:32] : '0;
    assign lo_o       = (rst && div_ready) ? div_res[31:0]  : '0;
    assign stallreq_o = rst & (div_busy | (is_div & ~div_busy & ~div_ready));
endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for ex: drivers push expected results, a monitor pops and
// compares when the ALU result is due or a HI/LO write appears.
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, stall_i, flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    always #5 clk = ~clk;

    ex #(.DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .stall_i(stall_i), .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq_o(stallreq_o)
    );

    typedef struct packed { logic w; logic [31:0] d; logic [4:0] wd; } alu_exp_t;
    typedef struct packed { logic [31:0] hi; logic [31:0] lo; } div_exp_t;

    alu_exp_t alu_q[$];
    div_exp_t div_q[$];
    string    alu_nm[$];
    string    div_nm[$];
    int       checks = 0;
    int       errors = 0;
    logic     alu_chk = 1'b0;
    logic     whilo_prev = 1'b0;
    alu_exp_t me;
    div_exp_t md;
    string    mn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference ALU from the instruction definitions, using wide signed arithmetic.
    function automatic void alu_ref(input logic [7:0] op, input logic [2:0] sel,
                                    input logic [31:0] a, input logic [31:0] b, input logic wr,
                                    output logic [31:0] d, output logic w);
        longint sa, sb, s;
        int     n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(a[4:0]);
        d  = '0;
        w  = wr;
        if (sel == SEL_LOGIC) begin
            if (op == OP_OR)  d = a | b;
            if (op == OP_AND) d = a & b;
            if (op == OP_XOR) d = a ^ b;
            if (op == OP_NOR) d = ~(a | b);
        end else if (sel == SEL_SHIFT) begin
            if (op == OP_SLL) d = b << n;
            if (op == OP_SRL) d = b >> n;
            if (op == OP_SRA) d = (b >> n) | (b[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
        end else if (sel == SEL_ARITH) begin
            if (op == OP_ADD || op == OP_ADDU) d = a + b;
            if (op == OP_SUB || op == OP_SUBU) d = a - b;
            if (op == OP_SLT)  d = (sa < sb) ? 32'd1 : 32'd0;
            if (op == OP_SLTU) d = (a < b) ? 32'd1 : 32'd0;
        end
        s = (op == OP_SUB) ? sa - sb : sa + sb;
        if ((op == OP_ADD || op == OP_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648))
            w = 1'b0;
    endfunction

    function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [2:0] sel_of(input logic [7:0] op);
        case (op)
            OP_OR, OP_AND, OP_XOR, OP_NOR, 8'h55: return SEL_LOGIC;
            OP_SLL, OP_SRL, OP_SRA:               return SEL_SHIFT;
            OP_NOP:                               return SEL_NOP;
            default:                              return SEL_ARITH;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            if (alu_chk) begin
                if (alu_q.size() == 0) chk("alu_queue_empty", 1, 0);
                else begin
                    me = alu_q.pop_front();
                    mn = alu_nm.pop_front();
                    chk({mn, " wdata"}, wdata_o, me.d);
                    chk({mn, " wreg"}, wreg_o, me.w);
                    chk({mn, " wd"}, wd_o, me.wd);
                    chk({mn, " stallreq"}, stallreq_o, 0);
                end
            end
            if (whilo_o && !whilo_prev) begin
                if (div_q.size() == 0) chk("unexpected_whilo", 1, 0);
                else begin
                    md = div_q.pop_front();
                    mn = div_nm.pop_front();
                    chk({mn, " hi"}, hi_o, md.hi);
                    chk({mn, " lo"}, lo_o, md.lo);
                    chk({mn, " wreg_in_done"}, wreg_o, 0);
                    chk({mn, " stallreq_in_done"}, stallreq_o, 0);
                end
            end
        end
        whilo_prev = whilo_o;
    end

    task automatic set_nop();
        aluop_i  = OP_NOP;
        alusel_i = SEL_NOP;
    endtask

    task automatic alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wr, input string nm);
        logic [31:0] d;
        logic        w;
        logic [4:0]  wd;
        @(posedge clk); #1;
        wd = 5'($urandom);
        aluop_i = op; alusel_i = sel_of(op); reg1_i = a; reg2_i = b; wreg_i = wr; wd_i = wd;
        alu_ref(op, sel_of(op), a, b, wr, d, w);
        alu_q.push_back('{w: w, d: d, wd: wd});
        alu_nm.push_back(nm);
        alu_chk = 1'b1;
        @(posedge clk); #1;
        alu_chk = 1'b0;
    endtask

    task automatic divop(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string nm);
        logic [63:0] r;
        int st, wh, c;
        bit seen;
        st = 0; wh = 0; c = 0; seen = 0;
        @(posedge clk); #1;
        aluop_i = sgn ? OP_DIV : OP_DIVU; alusel_i = SEL_ARITH;
        reg1_i = a; reg2_i = b; wreg_i = 1'b1;
        r = div_ref(sgn, a, b);
        div_q.push_back('{hi: r[63:32], lo: r[31:0]});
        div_nm.push_back(nm);
        while (!seen && c < 100) begin
            @(negedge clk);
            c++;
            if (whilo_o) seen = 1;
            else if (stallreq_o) st++;
        end
        chk({nm, " done_seen"}, 32'(seen), 1);
        chk({nm, " done_cycle"}, c - 1, (b == 0) ? 1 : 33);
        chk({nm, " stall_cycles"}, st, (b == 0) ? 1 : 33);
        if (seen) begin
            wh = 1;
            stall_i = (hold > 0);
            for (int k = 1; k <= hold + 1; k++) begin
                @(posedge clk); #1;
                if (k >= hold) begin stall_i = 1'b0; set_nop(); end
                @(negedge clk);
                if (whilo_o) wh++;
            end
            chk({nm, " whilo_cycles"}, wh, hold + 1);
        end
        stall_i = 1'b0;
        set_nop();
    endtask

    logic [7:0] rops [0:16] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                                 OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU,
                                 OP_NOP, 8'h55, OP_ADD, OP_SUB};
    logic [31:0] spec_vals [0:5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                      32'hFFFF_FFFF, 32'h0000_001F};

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(0, 2) == 0) return spec_vals[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wh;
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        aluop_i = OP_OR; alusel_i = SEL_LOGIC; reg1_i = 32'h0000_FF00; reg2_i = 32'h00FF_00FF;
        wd_i = 5'd7; wreg_i = 1'b1;
        #12;
        chk("reset wdata", wdata_o, 0);
        chk("reset wreg", wreg_o, 0);
        chk("reset wd", wd_o, 0);
        chk("reset whilo", whilo_o, 0);
        chk("reset hi", hi_o, 0);
        chk("reset lo", lo_o, 0);
        @(posedge clk); #1 rst = 1'b1;
        set_nop();

        alu(OP_OR,   32'h0000_FF00, 32'h00FF_00FF, 1'b1, "or");
        alu(OP_SRA,  32'd4,         32'h8000_0000, 1'b1, "sra");
        alu(OP_SLL,  32'd31,        32'd1,         1'b1, "sll");
        alu(OP_ADD,  32'h7FFF_FFFF, 32'd1,         1'b1, "add_ovf");
        alu(OP_ADDU, 32'h7FFF_FFFF, 32'd1,         1'b1, "addu_no_ovf");
        alu(OP_SUB,  32'h8000_0000, 32'd1,         1'b1, "sub_ovf");
        alu(OP_SLT,  32'hFFFF_FFFF, 32'd1,         1'b1, "slt");
        alu(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         1'b1, "sltu");
        alu(OP_NOP,  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "nop");

        divop(1'b1, 32'hFFFF_FFF9, 32'd2,          0, "div_m7_2");
        divop(1'b0, 32'd100,       32'd7,          0, "divu_100_7");
        divop(1'b0, 32'h1234_5678, 32'd0,          0, "divu_by_zero");
        divop(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  0, "div_min_m1");
        divop(1'b0, 32'd5,         32'd3,          3, "divu_stall_hold");

        // Flush while BUSY: no HI/LO write may follow.
        @(posedge clk); #1;
        aluop_i = OP_DIVU; alusel_i = SEL_ARITH; reg1_i = 32'd1000; reg2_i = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1; set_nop();
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        chk("flush busy stallreq_after", stallreq_o, 0);
        wh = 0;
        repeat (40) begin @(negedge clk); if (whilo_o) wh++; end
        chk("flush busy no_whilo", wh, 0);

        // Flush landing on the DONE cycle of a divide by zero.
        @(posedge clk); #1;
        aluop_i = OP_DIVU; alusel_i = SEL_ARITH; reg1_i = 32'd9; reg2_i = 32'd0;
        @(posedge clk); #1 flush_i = 1'b1; set_nop();
        @(negedge clk);
        chk("flush done whilo", whilo_o, 0);
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        chk("flush done whilo_after", whilo_o, 0);

        // Reset mid-divide.
        @(posedge clk); #1;
        aluop_i = OP_DIV; alusel_i = SEL_ARITH; reg1_i = 32'h0000_4000; reg2_i = 32'd7;
        wd_i = 5'd9; wreg_i = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst stallreq", stallreq_o, 0);
        chk("midrst whilo", whilo_o, 0);
        chk("midrst wd", wd_o, 0);
        chk("midrst wdata_hi_lo", wdata_o | hi_o | lo_o, 0);
        @(posedge clk); #1; set_nop(); rst = 1'b1;
        wh = 0;
        repeat (40) begin @(negedge clk); if (whilo_o) wh++; end
        chk("midrst no_whilo", wh, 0);

        for (int i = 0; i < 40; i++)
            alu(rops[$urandom_range(0, 16)], rnd_val(), rnd_val(), 1'($urandom), "rand_alu");
        for (int i = 0; i < 6; i++)
            divop(1'($urandom), rnd_val(),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : rnd_val(),
                  int'($urandom_range(0, 2)), "rand_div");

        repeat (3) @(negedge clk);
        chk("alu_queue_drained", alu_q.size(), 0);
        chk("div_queue_drained", div_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
